// File: rtl/nn_pkg.sv
// nn_pkg: shared data width, neuron FSM state encoding and output clamp limits.
package nn_pkg;
    localparam int DW = 8;
    localparam int Z_MAX = (1 << DW) - 1;
    localparam int Z_MIN = 0;
    typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUT} state_t;
endpackage

// File: rtl/mac_shift_sat.sv
// mac_shift_sat: arithmetic right shift of the accumulator and clamp to unsigned DW bits.
// NEURON_MAC_ROUND_EN adds half an LSB before the shift (round half up).
module mac_shift_sat
    import nn_pkg::*;
#(
    parameter int DW    = nn_pkg::DW,
    parameter int ACC_W = 20,
    parameter int SHIFT = 4
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [DW-1:0]    z
);
`ifdef NEURON_MAC_ROUND_EN
    localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(1) <<< (SHIFT - 1);
`else
    localparam logic signed [ACC_W:0] RND = '0;
`endif
    localparam logic signed [ACC_W:0] ZMAX = (ACC_W+1)'((1 << DW) - 1);
    logic signed [ACC_W:0] r, t;
    always_comb begin
        r = {acc[ACC_W-1], acc} + RND;
        t = r >>> SHIFT;
        z = t[ACC_W] ? DW'(Z_MIN) : (t > ZMAX) ? {DW{1'b1}} : t[DW-1:0];
    end
endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: serially accumulates x*w, adds shifted bias, rescales and saturates to z.
// Build option NEURON_MAC_ROUND_EN selects round-half-up rescaling in mac_shift_sat.
module neuron_mac
    import nn_pkg::*;
#(
    parameter int DW       = nn_pkg::DW,
    parameter int N_INPUTS = 4,
    parameter int ACC_W    = 20,
    parameter int SHIFT    = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 x_valid,
    output logic                 x_ready,
    input  logic        [DW-1:0] x_in,
    input  logic signed [DW-1:0] w_in,
    input  logic signed [DW-1:0] bias,
    output logic        [DW-1:0] z,
    output logic                 z_valid,
    output logic                 busy
);
    localparam int CW = $clog2(N_INPUTS + 1);
    state_t state, nxt;
    logic signed [ACC_W-1:0] acc;
    logic [CW-1:0] cnt;
    logic signed [2*DW:0] prod;
    logic hs, last;
    logic [DW-1:0] z_sat;
    // x is unsigned, so a zero MSB is prepended before the signed multiply
    assign prod = $signed({1'b0, x_in}) * w_in;
    always_comb begin
        x_ready = state == ACCUM;
        busy = state != IDLE;
        hs = x_ready && x_valid;
        last = hs && cnt == CW'(N_INPUTS - 1);
        nxt = state == IDLE  ? (start ? ACCUM : IDLE) :
              state == ACCUM ? (last ? BIAS : ACCUM) :
              state == BIAS  ? OUT : IDLE;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            acc <= '0;
            cnt <= '0;
            z <= '0;
            z_valid <= 1'b0;
        end else begin
            state <= nxt;
            z_valid <= state == OUT;
            if (state == IDLE && start) begin
                acc <= '0;
                cnt <= '0;
            end
            if (hs) begin
                acc <= acc + ACC_W'(prod);
                cnt <= cnt + 1'b1;
            end
            if (state == BIAS)
                acc <= acc + (ACC_W'(bias) <<< SHIFT);
            if (state == OUT)
                z <= z_sat;
        end
    end
    mac_shift_sat #(.DW(DW), .ACC_W(ACC_W), .SHIFT(SHIFT)) u_sat (
        .acc(acc),
        .z  (z_sat)
    );
endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Pre-activation stage of a neuron: serially accumulates N_INPUTS products x*w, adds a bias, rescales, and saturates the result to an unsigned DW-bit z.
- Sits directly upstream of the sigmoid lookup stage.
- Its z output drives that stage's z input, and its z_valid output drives that stage's enable input.
- Upstream of it is the layer sequencer, which streams activations and weights.

Parameters:
- DW, 8, width of x_in and z (unsigned) and of w_in and bias (signed two's complement)
- N_INPUTS, 4, products accumulated per neuron evaluation (>=1)
- ACC_W, 20, signed accumulator width; must hold N_INPUTS*(2^DW-1)*2^(DW-1) plus the shifted bias
- SHIFT, 4, right-shift applied to (sum + bias<<SHIFT) before saturation

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  begin a new evaluation; sampled only in IDLE
- x_valid  in  1  x_in/w_in pair valid
- x_ready  out  1  stage accepts a pair this cycle
- x_in  in  DW  activation, unsigned
- w_in  in  DW  weight, signed
- bias  in  DW  signed bias; sampled in the BIAS state
- z  out  DW  saturated pre-activation; held between evaluations
- z_valid  out  1  one-cycle pulse when z is updated
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous, active-low.
- Reset values: state=IDLE, acc=0, cnt=0, z=0, z_valid=0, x_ready=0, busy=0.
- State machine:
  - IDLE: start=1 -> clear acc and cnt, go to ACCUM. start=0 -> stay in IDLE.
  - ACCUM: x_ready=1. On a handshake (x_valid&&x_ready), acc += sext($signed({1'b0,x_in})*w_in) and cnt++. When the handshake carries cnt==N_INPUTS-1, go to BIAS. No handshake -> hold; stalls of any length are legal.
  - BIAS: x_ready=0. acc += sext(bias)<<<SHIFT. Go to OUT.
  - OUT: t = acc>>>SHIFT (arithmetic shift). z <= 0 if t<0; 2^DW-1 if t>2^DW-1; else t[DW-1:0]. z_valid<=1 for exactly this one registered cycle. Go to IDLE.
- Latency: last handshake at edge k -> z and z_valid visible after edge k+2.
- Minimum start-to-start spacing: N_INPUTS+3 cycles.
- start while busy is ignored; it is neither queued nor allowed to restart the evaluation.
- x_valid outside ACCUM is ignored, and no handshake occurs.
- z holds its last value until the next OUT state. z_valid is 0 in every state except the cycle after OUT.
- Saturation is evaluated on the full ACC_W value; no intermediate wrap is permitted within the ACC_W bound.
- Reset asserted mid-evaluation: immediate return to IDLE with all reset values; the partial sum is discarded.

Optional Feature:
- Macro: NEURON_MAC_ROUND_EN
- Defined: OUT computes t = (acc + (1<<(SHIFT-1)))>>>SHIFT, i.e. round half up. The rounding constant is added before the shift, and saturation uses the rounded value.
- Undefined: plain truncating arithmetic shift, as above.
- Latency and interface are identical in both builds.

Decomposition:
- Shared package nn_pkg: DW default, the state enum {IDLE, ACCUM, BIAS, OUT}, and the Z_MAX=2^DW-1 / Z_MIN=0 constants.
- The sigmoid stage also uses DW from nn_pkg.
- One combinational sub-module, mac_shift_sat:
  - inputs: ACC_W signed value
  - outputs: DW-bit saturated z
  - contains the shift, the optional rounding and the clamp
  - tested standalone.

Test Plan (defaults, truncating build unless noted):
- Basic: start; 4 pairs x=16, w=16; bias=0 -> z=64, z_valid high one cycle, exactly 2 cycles after the 4th handshake.
- Negative clamp: 4 pairs x=16, w=-16; bias=0 -> z=0. Then bias=-1 with all x=0 -> z=0.
- Positive saturation: 4 pairs x=255, w=127; bias=127 -> z=255. Also check acc=131572 and that no wrap occurs.
- Back-pressure and ignored start:
  - x_valid toggled 1,0,0,1,... over 4 pairs (x=1, w=32) -> x_ready stays high throughout, result z=8.
  - start pulsed during ACCUM -> result unchanged, busy never drops early.
- Rounding: single nonzero pair x=3, w=8 (sum 24), bias=0 -> z=1 without NEURON_MAC_ROUND_EN, z=2 with it.
- Reset mid-operation:
  - resetn low after 2 handshakes -> z=0, busy=0, x_ready=0 immediately (asynchronous).
  - After release, a fresh evaluation x=16, w=16 yields z=64 with no residue from the aborted sum.
